// File: rtl/keypad_encoder.sv
// keypad_encoder: debounced 10-key decimal keypad to BCD with one-cycle loadn strobe.
// Define KEYPAD_PRIORITY_EN to accept multi-key presses as their lowest set index.
module keypad_encoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [9:0] keys,
    input  logic       enable,
    output logic [3:0] data,
    output logic       loadn,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        EMIT,
        RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    state_t           state;
    state_t           state_d;
    logic [9:0]       k1;
    logic [9:0]       ks;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic [3:0]       enc;
    logic [3:0]       enc_q;
    logic [3:0]       data_d;
    logic             valid;
    logic             match;

    // lowest set index; for a one-hot pattern this is simply its index
    always_comb begin
        enc = 4'd0;
        for (int i = 9; i >= 0; i--) begin
            if (ks[i]) enc = 4'(i);
        end
    end

`ifdef KEYPAD_PRIORITY_EN
    assign valid = |ks;
    assign match = valid && (enc == enc_q);
`else
    logic [9:0] pat;

    always_ff @(posedge clk) begin
        if (clr) begin
            pat <= '0;
        end else if (state == IDLE) begin
            pat <= ks;
        end
    end

    assign valid = $onehot(ks);
    assign match = (ks == pat);
`endif

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        data_d  = data;
        unique case (state)
            IDLE: begin
                cnt_d = '0;
                if (enable && valid) begin
                    state_d = DEBOUNCE;
                    cnt_d   = ONE;
                end
            end
            DEBOUNCE: begin
                if (!enable || !match) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt == LIMIT) begin
                    state_d = EMIT;
                    cnt_d   = '0;
                    data_d  = enc_q;
                end else begin
                    cnt_d = cnt + ONE;
                end
            end
            EMIT: begin
                state_d = RELEASE;
                cnt_d   = '0;
            end
            RELEASE: begin
                // enable is deliberately ignored so a held key cannot re-trigger
                if (ks != '0) begin
                    cnt_d = '0;
                end else if (cnt == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            k1    <= '0;
            ks    <= '0;
            state <= IDLE;
            cnt   <= '0;
            enc_q <= 4'd0;
            data  <= 4'd0;
            loadn <= 1'b1;
            busy  <= 1'b0;
        end else begin
            k1    <= keys;
            ks    <= k1;
            state <= state_d;
            cnt   <= cnt_d;
            data  <= data_d;
            loadn <= (state != EMIT);
            busy  <= (state_d != IDLE);
            if (state == IDLE) enc_q <= enc;
        end
    end

endmodule

// File: tb/tb_keypad_encoder.sv
// tb_keypad_encoder: directed stimulus with a strobe scoreboard for keypad_encoder.
module tb_keypad_encoder;

    localparam int N = 4;

    typedef struct {
        logic [3:0] d;
        int         lo;
        int         hi;
    } exp_t;

    logic       clk;
    logic       clr;
    logic [9:0] keys;
    logic       enable;
    logic [3:0] data;
    logic       loadn;
    logic       busy;

    int   ncmp;
    int   nmis;
    int   ecount;
    exp_t sb[$];
    logic [3:0] data_prev;
    logic [3:0] t_min;
    logic [3:0] t_dec;
    logic [3:0] t_one;

    keypad_encoder #(
        .DEBOUNCE_CYCLES(N),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .clr(clr),
        .keys(keys),
        .enable(enable),
        .data(data),
        .loadn(loadn),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial ecount = 0;
    always @(posedge clk) ecount <= ecount + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // expected strobe for a key pattern first sampled at edge index t0
    task automatic expect_strobe(input logic [3:0] d, input int lo, input int hi);
        exp_t e;
        e.d  = d;
        e.lo = lo;
        e.hi = hi;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (clr !== 1'b1 && loadn === 1'b0) begin
            chk("strobe_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("strobe_data", 32'(data), 32'(e.d));
                chk("data_setup", 32'(data_prev), 32'(e.d));
                chk("strobe_time", 32'(ecount >= e.lo && ecount <= e.hi), 32'd1);
            end
            t_min = t_dec;
            t_dec = t_one;
            t_one = data;
        end
        data_prev = data;
    end

    initial begin
        int t0;
        ncmp   = 0;
        nmis   = 0;
        t_min  = 4'd0;
        t_dec  = 4'd0;
        t_one  = 4'd0;
        clr    = 1'b1;
        keys   = 10'h020;
        enable = 1'b1;

        // reset with a key already held
        tick(2);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_loadn", 32'(loadn), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        clr = 1'b0;
        t0  = ecount;
        expect_strobe(4'd5, t0 + N + 4, t0 + N + 4);
        tick(2);
        chk("idle_until_sync", 32'(busy), 32'd0);
        tick(1);
        chk("debounce_busy", 32'(busy), 32'd1);
        tick(17);
        chk("held_release_busy", 32'(busy), 32'd1);
        keys = '0;
        tick(8);
        chk("release_idle", 32'(busy), 32'd0);

        // clean press of 5
        keys = 10'h020;
        t0   = ecount;
        expect_strobe(4'd5, t0 + N + 4, t0 + N + 4);
        tick(20);
        chk("clean_data_hold", 32'(data), 32'd5);
        keys = '0;
        tick(8);

        // bounce on key 9
        keys = 10'h200;
        tick(2);
        keys = '0;
        tick(2);
        keys = 10'h200;
        t0   = ecount;
        expect_strobe(4'd9, t0 + N + 4, t0 + N + 4);
        tick(20);
        keys = '0;
        tick(8);
        chk("bounce_idle", 32'(busy), 32'd0);

        // keys 3 and 7 together
        keys = 10'h088;
        t0   = ecount;
`ifdef KEYPAD_PRIORITY_EN
        expect_strobe(4'd3, t0 + N + 4, t0 + N + 4);
        tick(20);
        chk("multi_busy", 32'(busy), 32'd1);
`else
        tick(20);
        chk("multi_busy", 32'(busy), 32'd0);
`endif
        keys = '0;
        tick(8);

        // enable gating
        enable = 1'b0;
        keys   = 10'h004;
        tick(12);
        chk("gated_busy", 32'(busy), 32'd0);
        enable = 1'b1;
        t0     = ecount;
        expect_strobe(4'd2, t0 + N + 2, t0 + N + 4);
        tick(12);
        keys = '0;
        tick(8);

        // enable falls mid-debounce
        keys = 10'h004;
        tick(4);
        chk("abort_pre_busy", 32'(busy), 32'd1);
        enable = 1'b0;
        tick(2);
        chk("abort_busy", 32'(busy), 32'd0);
        keys   = '0;
        enable = 1'b1;
        tick(8);

        // enable falls during the strobe state
        keys = 10'h080;
        t0   = ecount;
        expect_strobe(4'd7, t0 + N + 4, t0 + N + 4);
        tick(N + 3);
        enable = 1'b0;
        tick(6);
        keys = '0;
        tick(8);
        enable = 1'b1;
        chk("emit_enable_idle", 32'(busy), 32'd0);

        // digit sequence into a timer
        t_min = 4'd0;
        t_dec = 4'd0;
        t_one = 4'd0;
        keys  = 10'h002;
        t0    = ecount;
        expect_strobe(4'd1, t0 + N + 4, t0 + N + 4);
        tick(10);
        keys = '0;
        tick(8);
        keys = 10'h004;
        t0   = ecount;
        expect_strobe(4'd2, t0 + N + 4, t0 + N + 4);
        tick(10);
        keys = '0;
        tick(8);
        keys = 10'h001;
        t0   = ecount;
        expect_strobe(4'd0, t0 + N + 4, t0 + N + 4);
        tick(10);
        keys = '0;
        tick(8);
        chk("timer_mins", 32'(t_min), 32'd1);
        chk("timer_sec_decs", 32'(t_dec), 32'd2);
        chk("timer_sec_ones", 32'(t_one), 32'd0);

        // clr in the middle of a debounce
        keys = 10'h100;
        tick(4);
        chk("clr_pre_busy", 32'(busy), 32'd1);
        clr = 1'b1;
        tick(1);
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_data", 32'(data), 32'd0);
        chk("clr_loadn", 32'(loadn), 32'd1);
        clr  = 1'b0;
        keys = '0;
        tick(10);
        chk("clr_no_strobe", 32'(busy), 32'd0);

        chk("pending", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
        $finish;
    end

endmodule
